// File: rtl/blink_code_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : blink_code_arb_if
// Brief   : Request/code inputs and grant/status outputs of the blink arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface blink_code_arb_if #(
   parameter int N_REQ  = 4,
   parameter int W_CODE = 4
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*W_CODE-1:0] code;
   logic [N_REQ-1:0]        grant;
   logic                    busy;
   logic                    done;
   logic                    led;

   modport master (output req, code, input  grant, busy, done, led);
   modport slave  (input  req, code, output grant, busy, done, led);
endinterface
`default_nettype wire

// File: rtl/blink_code_arb.sv
`default_nettype none
// ============================================================================
// Module  : blink_code_arb
// Brief   : Round-robin arbiter that blinks the winner's code count on an LED.
// Revision: 1.0 - initial release
// ============================================================================
module blink_code_arb #(
   parameter int CLK_HZ    = 12_000_000,
   parameter int UNIT_HZ   = 8,
   parameter int N_REQ     = 4,
   parameter int W_CODE    = 4,
   parameter int GAP_UNITS = 6
) (
   input  wire              clk,
   input  wire              rst,
   blink_code_arb_if.slave  bus
);
   localparam int TICK_DIV = CLK_HZ / UNIT_HZ;
   localparam int GAP_CYC  = GAP_UNITS * TICK_DIV;
   localparam int CNT_MAX  = (GAP_CYC > TICK_DIV) ? GAP_CYC : TICK_DIV;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [CNT_W-1:0] TICK_LOAD = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q,   ptr_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [W_CODE-1:0] rem_q,   rem_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              led_q,   led_d;

   logic [N_REQ-1:0]  w_elig;
   logic              w_found;
   logic [PTR_W-1:0]  w_win;
   logic [PTR_W-1:0]  w_nxt_ptr;
   logic [W_CODE-1:0] w_win_code;
   logic [W_CODE-1:0] w_rem_dec;

   // A zero code would produce an empty sequence, so it never competes.
   for (genvar i = 0; i < N_REQ; i++) begin : g_elig
      assign w_elig[i] = bus.req[i] & (|bus.code[i*W_CODE +: W_CODE]);
   end

   always_comb begin : arb_search
      int idx;
      idx        = 0;
      w_found    = 1'b0;
      w_win      = '0;
      w_nxt_ptr  = ptr_q;
      w_win_code = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!w_found && w_elig[idx]) begin
            w_found    = 1'b1;
            w_win      = PTR_W'(idx);
            w_nxt_ptr  = PTR_W'((idx + 1) % N_REQ);
            w_win_code = bus.code[idx*W_CODE +: W_CODE];
         end
      end
   end

   assign w_rem_dec = rem_q - 1'b1;

   always_comb begin : next_state
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      led_d   = led_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            led_d   = 1'b0;
            if (w_found) begin
               state_d = S_ON;
               for (int j = 0; j < N_REQ; j++) begin
                  grant_d[j] = (PTR_W'(j) == w_win);
               end
               busy_d  = 1'b1;
               led_d   = 1'b1;
               rem_d   = w_win_code;
               cnt_d   = TICK_LOAD;
               ptr_d   = w_nxt_ptr;
            end
         end
         S_ON: begin
            if (cnt_q == '0) begin
               state_d = S_OFF;
               led_d   = 1'b0;
               cnt_d   = TICK_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_OFF: begin
            if (cnt_q == '0) begin
               rem_d = w_rem_dec;
               if (w_rem_dec != '0) begin
                  state_d = S_ON;
                  led_d   = 1'b1;
                  cnt_d   = TICK_LOAD;
               end else begin
                  state_d = S_GAP;
                  cnt_d   = GAP_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         led_q   <= led_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.led   = led_q;
endmodule
`default_nettype wire

// File: tb/tb_blink_code_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_blink_code_arb
// Brief   : Scoreboard bench for blink_code_arb (TICK_DIV=4, GAP_UNITS=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_blink_code_arb;
   localparam int N = 4;
   localparam int W = 4;

   typedef struct {
      logic [N-1:0] g;
      int           pulses;
      int           busy_len;
      int           led_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   exp_t exp_q[$];

   blink_code_arb_if #(.N_REQ(N), .W_CODE(W)) bus ();

   blink_code_arb #(
      .CLK_HZ(8), .UNIT_HZ(2), .N_REQ(N), .W_CODE(W), .GAP_UNITS(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic ok,
                        input logic [31:0] act, input logic [31:0] req_v);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req_v, $time);
   endtask

   function automatic exp_t mk(input logic [N-1:0] g, input int c);
      exp_t e;
      e.g = g; e.pulses = c; e.busy_len = (2*c + 2)*4; e.led_cyc = c*4;
      return e;
   endfunction

   // Monitor: measures every completed sequence and matches it to the queue.
   initial begin : monitor
      logic         in_seq, prev_led;
      logic [N-1:0] seq_g;
      int           blen, pul, lcyc;
      exp_t         e;
      in_seq = 1'b0; prev_led = 1'b0; seq_g = '0; blen = 0; pul = 0; lcyc = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_seq = 1'b0;
         end else begin
            if ($countones(bus.grant) > 1)
               check("grant_onehot", 1'b0, 32'(bus.grant), 0);
            if (bus.led && !bus.busy)
               check("led_implies_busy", 1'b0, 32'(bus.busy), 1);
            if (bus.busy && !in_seq) begin
               in_seq = 1'b1; seq_g = bus.grant; blen = 0; pul = 0; lcyc = 0; prev_led = 1'b0;
            end
            if (in_seq && bus.busy) begin
               blen++;
               if (bus.led && !prev_led) pul++;
               if (bus.led) lcyc++;
               prev_led = bus.led;
               if (bus.grant != seq_g)
                  check("grant_stable", 1'b0, 32'(bus.grant), 32'(seq_g));
            end
            if (bus.done) begin
               check("done_busy_low", !bus.busy, 32'(bus.busy), 0);
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 1'b0, 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_grant",   seq_g == e.g,        32'(seq_g), 32'(e.g));
                  check("sb_pulses",  pul == e.pulses,     32'(pul),   32'(e.pulses));
                  check("sb_busylen", blen == e.busy_len,  32'(blen),  32'(e.busy_len));
                  check("sb_ledcyc",  lcyc == e.led_cyc,   32'(lcyc),  32'(e.led_cyc));
               end
               in_seq = 1'b0;
            end
         end
      end
   end

   task automatic wait_done(input int max_cyc, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check(name, seen, 32'(seen), 1);
   endtask

   // Code-2 sequence on requester 1, checked cycle by cycle; inputs change at drop_cyc.
   task automatic run_profile(input int drop_cyc, input logic [N*W-1:0] new_code, input string tag);
      logic exp_led;
      bus.req = 4'b0010; bus.code = 16'h0020;
      exp_q.push_back(mk(4'b0010, 2));
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         exp_led = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
         check({tag, "_led"},  bus.led  == exp_led,  32'(bus.led),  32'(exp_led));
         check({tag, "_busy"}, bus.busy == (c <= 24), 32'(bus.busy), 32'(c <= 24));
         check({tag, "_done"}, bus.done == (c == 25), 32'(bus.done), 32'(c == 25));
         if (c == 1) check({tag, "_grant"}, bus.grant == 4'b0010, 32'(bus.grant), 2);
         if (c == drop_cyc) begin
            bus.req = '0; bus.code = new_code;
         end
      end
   endtask

   initial begin : stim
      logic act;
      bus.req = '0; bus.code = '0;
      #2;
      check("rst_grant", bus.grant == '0, 32'(bus.grant), 0);
      check("rst_busy",  bus.busy  == 0,  32'(bus.busy),  0);
      check("rst_done",  bus.done  == 0,  32'(bus.done),  0);
      check("rst_led",   bus.led   == 0,  32'(bus.led),   0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single request, code 2
      run_profile(1, 16'h0020, "single");

      // Round-robin from a fresh pointer
      @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
      bus.req = 4'b0101; bus.code = 16'h1111;
      exp_q.push_back(mk(4'b0001, 1));
      exp_q.push_back(mk(4'b0100, 1));
      exp_q.push_back(mk(4'b0001, 1));
      wait_done(40, "rr_done1");
      wait_done(40, "rr_done2");
      wait_done(40, "rr_done3");
      bus.req = '0;

      // Zero code never wins
      @(negedge clk);
      bus.req = 4'b1000; bus.code = 16'h0000; act = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.busy || bus.led || bus.grant != '0) act = 1'b1;
      end
      check("zero_code_idle", !act, 32'(act), 0);
      bus.req = '0;

      // Non-preemption: requester drops and code changes mid-sequence
      @(negedge clk);
      run_profile(3, 16'h0070, "nopre");

      // Asynchronous reset mid-sequence
      @(negedge clk);
      bus.req = 4'b0001; bus.code = 16'h0003;
      repeat (6) @(posedge clk);
      #2;
      check("pre_rst_busy", bus.busy == 1, 32'(bus.busy), 1);
      rst = 1'b1;
      bus.req = 4'b0011; bus.code = 16'h0011;
      #1;
      check("async_led",   bus.led   == 0,  32'(bus.led),   0);
      check("async_busy",  bus.busy  == 0,  32'(bus.busy),  0);
      check("async_grant", bus.grant == '0, 32'(bus.grant), 0);
      check("async_done",  bus.done  == 0,  32'(bus.done),  0);
      @(negedge clk); #2;
      rst = 1'b0;
      exp_q.push_back(mk(4'b0001, 1));
      @(negedge clk);
      check("post_rst_grant", bus.grant == 4'b0001, 32'(bus.grant), 1);
      bus.req = '0;
      wait_done(40, "post_rst_done");

      // Maximum code
      @(negedge clk);
      bus.req = 4'b0001; bus.code = 16'h000F;
      exp_q.push_back(mk(4'b0001, 15));
      @(negedge clk);
      bus.req = '0;
      wait_done(200, "max_done");

      repeat (10) @(negedge clk);
      check("sb_empty", exp_q.size() == 0, 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
`default_nettype wire
